// File: rtl/uarch_pkg.sv
// Shared micro-architecture constants and types for the instruction front end.
package uarch_pkg;

    localparam int unsigned CPU_ADDR_BITS         = 32;
    localparam int unsigned CPU_INST_BITS         = 32;
    localparam int unsigned FETCH_PACKET_INSTS    = 2;
    localparam int unsigned FETCH_MAX_OUTSTANDING = 2;

    localparam logic [CPU_ADDR_BITS-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Redirect targets are forced onto an instruction boundary.
    function automatic logic [CPU_ADDR_BITS-1:0] align_pc(input logic [CPU_ADDR_BITS-1:0] a);
        return a & ~CPU_ADDR_BITS'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response and instruction-buffer delivery bundle.
interface fetch_unit_if
    import uarch_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = FETCH_PACKET_INSTS
);

    localparam int unsigned PKT_W = FETCH_WIDTH * CPU_INST_BITS;

    logic [CPU_ADDR_BITS-1:0] imem_req_addr;
    logic                     imem_req_val;
    logic                     imem_req_rdy;
    logic [PKT_W-1:0]         imem_resp_data;
    logic                     imem_resp_val;
    logic [CPU_ADDR_BITS-1:0] pc;
    logic [PKT_W-1:0]         imem_rec_packet;
    logic                     imem_rec_val;
    logic                     inst_buffer_rdy;

    modport master (
        output imem_req_addr, imem_req_val,
        input  imem_req_rdy,
        input  imem_resp_data, imem_resp_val,
        output pc, imem_rec_packet, imem_rec_val,
        input  inst_buffer_rdy
    );

    modport slave (
        input  imem_req_addr, imem_req_val,
        output imem_req_rdy,
        output imem_resp_data, imem_resp_val,
        input  pc, imem_rec_packet, imem_rec_val,
        output inst_buffer_rdy
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with synchronous clear; head is readable whenever non-empty.
module fetch_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pops on empty and pushes on full (without a same-cycle pop) are ignored.
    assign do_pop  = pop & ~empty;
    assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch engine: credit-limited aligned packet requests, in-order tag pairing,
// and flush redirect with stale-response kill counting.
module fetch_unit
    import uarch_pkg::*;
#(
    parameter int unsigned              FETCH_WIDTH     = FETCH_PACKET_INSTS,
    parameter int unsigned              MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
    parameter logic [CPU_ADDR_BITS-1:0] RESET_PC        = uarch_pkg::RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [CPU_ADDR_BITS-1:0] redirect_pc,
    fetch_unit_if.master             fif
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned PKT_W = FETCH_WIDTH * CPU_INST_BITS;
    localparam int unsigned ENT_W = CPU_ADDR_BITS + PKT_W;
    localparam int unsigned STEP  = FETCH_WIDTH * 4;

    fetch_state_t             state;
    logic [CPU_ADDR_BITS-1:0] fetch_pc;
    logic [CNT_W-1:0]         inflight;
    logic [CNT_W-1:0]         kill_cnt;

    logic [CPU_ADDR_BITS-1:0] tag_head;
    logic [CNT_W-1:0]         tag_count;
    logic                     tag_empty;
    logic [ENT_W-1:0]         q_head;
    logic [CNT_W-1:0]         q_count;
    logic                     q_empty;

    logic             req_val_c;
    logic             accept;
    logic             resp_live;
    logic             resp_keep;
    logic             resp_drop;
    logic             rec_val_c;
    logic             deliver;
    logic [CNT_W-1:0] kill_on_flush;
    logic [CNT_W-1:0] kill_dec;

    // Credits cover both in-flight requests and packets parked in the queue,
    // so the response queue can never overflow.
    assign req_val_c = (state == RUN) & ~flush &
                       (((CNT_W+1)'(inflight) + (CNT_W+1)'(q_count)) < (CNT_W+1)'(MAX_OUTSTANDING));
    assign accept    = req_val_c & fif.imem_req_rdy;

    // A response with nothing in flight is a memory protocol error and is ignored.
    assign resp_live = fif.imem_resp_val & (inflight != '0);
    assign resp_drop = resp_live & (kill_cnt != '0);
    assign resp_keep = resp_live & (kill_cnt == '0) & ~flush;

    assign rec_val_c = ~q_empty & ~flush;
    assign deliver   = rec_val_c & fif.inst_buffer_rdy;

    assign kill_on_flush = inflight - CNT_W'(resp_live);
    assign kill_dec      = kill_cnt - CNT_W'(resp_drop);

    fetch_fifo #(
        .WIDTH (CPU_ADDR_BITS),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (resp_live),
        .head      (tag_head),
        .count     (tag_count),
        .empty     (tag_empty)
    );

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (resp_keep),
        .push_data ({tag_head, fif.imem_resp_data}),
        .pop       (deliver),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty)
    );

    assign fif.imem_req_val    = req_val_c;
    assign fif.imem_req_addr   = fetch_pc;
    assign fif.imem_rec_val    = rec_val_c;
    assign fif.pc              = q_head[ENT_W-1:PKT_W];
    assign fif.imem_rec_packet = q_head[PKT_W-1:0];

    // Flush outranks every other update; responses still owed by memory become kills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            inflight <= '0;
            kill_cnt <= '0;
        end else if (flush) begin
            fetch_pc <= align_pc(redirect_pc);
            kill_cnt <= kill_on_flush;
            inflight <= kill_on_flush;
            state    <= (kill_on_flush != '0) ? DRAIN : RUN;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + CPU_ADDR_BITS'(STEP);
            end
            inflight <= inflight + CNT_W'(accept) - CNT_W'(resp_live);
            kill_cnt <= kill_dec;
            case (state)
                BOOT:    state <= RUN;
                RUN:     state <= RUN;
                DRAIN:   state <= (kill_dec == '0) ? RUN : DRAIN;
                default: state <= BOOT;
            endcase
        end
    end

    a_resp_has_credit: assert property (@(posedge clk) disable iff (!rst_n)
        fif.imem_resp_val |-> (inflight != '0));

    a_tag_balance: assert property (@(posedge clk) disable iff (!rst_n)
        (tag_count == (inflight - kill_cnt)) && (tag_empty == (tag_count == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order latency memory model and a delivery scoreboard.
module tb_fetch_unit;
    import uarch_pkg::*;

    localparam int unsigned PKT_W = FETCH_PACKET_INSTS * CPU_INST_BITS;

    typedef logic [CPU_ADDR_BITS-1:0] addr_t;
    typedef logic [PKT_W-1:0]         pkt_t;
    typedef struct packed {
        addr_t pc;
        pkt_t  pkt;
    } deliv_t;

    logic  clk         = 1'b0;
    logic  rst_n       = 1'b0;
    logic  flush       = 1'b0;
    addr_t redirect_pc = '0;

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int epoch = 0;

    addr_t  mq_addr[$];
    int     mq_rem[$];
    int     mq_epoch[$];
    addr_t  resp_addr;
    int     resp_epoch;
    deliv_t exp_q[$];
    addr_t  acc_log[$];
    addr_t  del_log[$];

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .fif         (bus)
    );

    always #5 clk = ~clk;

    function automatic pkt_t mem_pkt(input addr_t a);
        pkt_t p;
        for (int i = 0; i < int'(FETCH_PACKET_INSTS); i++) begin
            p[i*CPU_INST_BITS +: CPU_INST_BITS] = (a + addr_t'(4*i)) ^ addr_t'(32'hC0DE_0000);
        end
        return p;
    endfunction

    // Memory: fixed latency, in order; a sampled response is expected to be
    // delivered only if issued after the last flush and not hit by a flush itself.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq_addr.delete();
            mq_rem.delete();
            mq_epoch.delete();
            exp_q.delete();
            epoch = 0;
            resp_epoch = -1;
            resp_addr = '0;
            bus.imem_resp_val  <= 1'b0;
            bus.imem_resp_data <= '0;
        end else begin
            if (bus.imem_resp_val && resp_epoch == epoch && !flush)
                exp_q.push_back('{pc: resp_addr, pkt: bus.imem_resp_data});
            if (flush) epoch++;
            foreach (mq_rem[i]) mq_rem[i]--;
            if (bus.imem_req_val && bus.imem_req_rdy) begin
                mq_addr.push_back(bus.imem_req_addr);
                mq_rem.push_back(lat - 1);
                mq_epoch.push_back(epoch);
            end
            if (mq_rem.size() > 0 && mq_rem[0] <= 0) begin
                resp_addr  = mq_addr.pop_front();
                resp_epoch = mq_epoch.pop_front();
                void'(mq_rem.pop_front());
                bus.imem_resp_val  <= 1'b1;
                bus.imem_resp_data <= mem_pkt(resp_addr);
            end else begin
                bus.imem_resp_val <= 1'b0;
            end
        end
    end

    // Monitor: log accepted requests, score deliveries against the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.imem_req_val && bus.imem_req_rdy) acc_log.push_back(bus.imem_req_addr);
            if (bus.imem_rec_val && bus.inst_buffer_rdy) begin
                del_log.push_back(bus.pc);
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL deliv_unexpected observed pc=%h expected=none", bus.pc);
                end
                if (exp_q.size() != 0) begin
                    deliv_t e;
                    e = exp_q.pop_front();
                    total++;
                    assert (bus.pc === e.pc) else begin
                        bad++;
                        $error("FAIL deliv_pc observed=%h expected=%h", bus.pc, e.pc);
                    end
                    total++;
                    assert (bus.imem_rec_packet === e.pkt) else begin
                        bad++;
                        $error("FAIL deliv_pkt observed=%h expected=%h", bus.imem_rec_packet, e.pkt);
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic addr_t log_at(input addr_t q[$], input int i);
        return (i < q.size()) ? q[i] : '1;
    endfunction

    // Reset for one cycle, release, and check the BOOT cycle and the first request.
    task automatic start(input int l, input logic rrdy, input logic brdy);
        rst_n = 1'b0;
        flush = 1'b0;
        lat = l;
        bus.imem_req_rdy = rrdy;
        bus.inst_buffer_rdy = brdy;
        @(posedge clk);
        #1;
        acc_log.delete();
        del_log.delete();
        rst_n = 1'b1;
        #3;
        check("boot_req_val", 64'(bus.imem_req_val), 64'd0);
        cycles(1);
        check("first_req_val", 64'(bus.imem_req_val), 64'd1);
        check("first_req_addr", 64'(bus.imem_req_addr), 64'(RESET_PC));
    endtask

    initial begin
        bus.imem_req_rdy = 1'b1;
        bus.inst_buffer_rdy = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_val", 64'(bus.imem_req_val), 64'd0);
        check("rst_req_addr", 64'(bus.imem_req_addr), 64'(RESET_PC));
        check("rst_rec_val", 64'(bus.imem_rec_val), 64'd0);
        check("rst_pc", 64'(bus.pc), 64'd0);
        check("rst_packet", 64'(bus.imem_rec_packet), 64'd0);

        // Streaming with L=1, everything ready
        start(1, 1'b1, 1'b1);
        cycles(8);
        bus.imem_req_rdy = 1'b0;
        cycles(6);
        check("s_acc_ge4", 64'(acc_log.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("s_req%0d", i), 64'(log_at(acc_log, i)), 64'(8*i));
            check($sformatf("s_del%0d", i), 64'(log_at(del_log, i)), 64'(8*i));
        end
        check("s_del_count", 64'(del_log.size()), 64'(acc_log.size()));
        check("s_exp_drained", 64'(exp_q.size()), 64'd0);
        check("s_hold_val", 64'(bus.imem_req_val), 64'd1);
        check("s_hold_addr", 64'(bus.imem_req_addr), 64'(8*acc_log.size()));

        // Buffer stalled: credits cap requests at two
        start(1, 1'b1, 1'b0);
        cycles(6);
        check("bp_acc_cnt", 64'(acc_log.size()), 64'd2);
        check("bp_req0", 64'(log_at(acc_log, 0)), 64'h0);
        check("bp_req1", 64'(log_at(acc_log, 1)), 64'h8);
        check("bp_req_val", 64'(bus.imem_req_val), 64'd0);
        check("bp_rec_val", 64'(bus.imem_rec_val), 64'd1);
        check("bp_head_pc", 64'(bus.pc), 64'h0);
        bus.inst_buffer_rdy = 1'b1;
        cycles(1);
        check("bp_rec_val2", 64'(bus.imem_rec_val), 64'd1);
        check("bp_head_pc2", 64'(bus.pc), 64'h8);
        check("bp_req_val2", 64'(bus.imem_req_val), 64'd1);
        check("bp_req_addr2", 64'(bus.imem_req_addr), 64'h10);
        bus.imem_req_rdy = 1'b0;
        cycles(5);
        check("bp_del_count", 64'(del_log.size()), 64'd2);
        check("bp_exp_drained", 64'(exp_q.size()), 64'd0);

        // Memory not ready: request held
        start(1, 1'b1, 1'b1);
        cycles(1);
        bus.imem_req_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("h_val%0d", i), 64'(bus.imem_req_val), 64'd1);
            check($sformatf("h_addr%0d", i), 64'(bus.imem_req_addr), 64'h8);
            cycles(1);
        end
        check("h_acc_cnt", 64'(acc_log.size()), 64'd1);
        bus.imem_req_rdy = 1'b1;
        cycles(1);
        check("h_req1", 64'(log_at(acc_log, 1)), 64'h8);
        check("h_next_addr", 64'(bus.imem_req_addr), 64'h10);
        bus.imem_req_rdy = 1'b0;
        cycles(5);
        check("h_del_count", 64'(del_log.size()), 64'd2);
        check("h_exp_drained", 64'(exp_q.size()), 64'd0);

        // L=3, flush with two requests in flight
        start(3, 1'b1, 1'b1);
        cycles(1);
        check("f_req_val_1", 64'(bus.imem_req_val), 64'd1);
        check("f_req_addr_1", 64'(bus.imem_req_addr), 64'h8);
        cycles(1);
        check("f_credit_stop", 64'(bus.imem_req_val), 64'd0);
        flush = 1'b1;
        redirect_pc = 32'h100;
        cycles(1);
        flush = 1'b0;
        check("f_drain_val_a", 64'(bus.imem_req_val), 64'd0);
        check("f_drain_rec_a", 64'(bus.imem_rec_val), 64'd0);
        cycles(1);
        check("f_drain_val_b", 64'(bus.imem_req_val), 64'd0);
        check("f_drain_rec_b", 64'(bus.imem_rec_val), 64'd0);
        cycles(1);
        check("f_run_val", 64'(bus.imem_req_val), 64'd1);
        check("f_run_addr", 64'(bus.imem_req_addr), 64'h100);
        cycles(6);
        bus.imem_req_rdy = 1'b0;
        cycles(8);
        check("f_first_del", 64'(log_at(del_log, 0)), 64'h100);
        check("f_del_count", 64'(del_log.size() + 2), 64'(acc_log.size()));
        check("f_exp_drained", 64'(exp_q.size()), 64'd0);

        // Flush coincident with the only in-flight response
        start(1, 1'b1, 1'b1);
        cycles(1);
        flush = 1'b1;
        redirect_pc = 32'h203;
        #1;
        check("fr_val_drop", 64'(bus.imem_req_val), 64'd0);
        check("fr_rec_drop", 64'(bus.imem_rec_val), 64'd0);
        cycles(1);
        flush = 1'b0;
        #1;
        check("fr_resp_dropped", 64'(bus.imem_rec_val), 64'd0);
        check("fr_run_val", 64'(bus.imem_req_val), 64'd1);
        check("fr_run_addr", 64'(bus.imem_req_addr), 64'h200);
        cycles(4);
        bus.imem_req_rdy = 1'b0;
        cycles(4);
        check("fr_req1", 64'(log_at(acc_log, 1)), 64'h200);
        check("fr_first_del", 64'(log_at(del_log, 0)), 64'h200);
        check("fr_exp_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with a full response queue
        start(1, 1'b1, 1'b0);
        cycles(5);
        check("ar_rec_full", 64'(bus.imem_rec_val), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_rec_val", 64'(bus.imem_rec_val), 64'd0);
        check("ar_req_val", 64'(bus.imem_req_val), 64'd0);
        check("ar_pc", 64'(bus.pc), 64'd0);
        check("ar_req_addr", 64'(bus.imem_req_addr), 64'(RESET_PC));
        start(1, 1'b1, 1'b1);
        cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
